fetch_pair_queue: RTL and testbench

//  Decoupling queue on the receive side of the dual fetch path. Accepts 0-2 fetched
//  {pc, instruction} slots per cycle from the fetch stage and presents the oldest 0-2

---
 rtl/fetch_pair_queue.sv | 115 +++++++++++
 tb/tb_fetch_pair_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: circular decoupling queue between the dual fetch path and decode.
// Fetch pushes 0-2 {pc, instr} slots per cycle. Decode sees the two oldest entries
// and retires 0-2 per cycle. Flush empties the queue on a branch miss or redirect.
//
// Handshake: a fetch slot is taken on a rising edge only if in_ready was high during
// that cycle. in_ready is high only when at least two entries are free, so a pair is
// always taken whole or not at all. A pair that is not taken is held by fetch and
// presented again. The decode side works as follows: an output slot is consumed when
// its deq bit is high while its out_valid is high. deq2 counts only when deq1 is also
// high. Acceptance is judged from the count at the start of the cycle. A dequeue in
// the same cycle never creates room for an enqueue.
module fetch_pair_queue #(
    parameter int          DEPTH = 8,
    parameter int          CNT_W = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic [14:0]      in_pc1,
    input  logic [14:0]      in_pc2,
    input  logic [31:0]      in_instr1,
    input  logic [31:0]      in_instr2,
    output logic             in_ready,
    input  logic             deq1,
    input  logic             deq2,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic [14:0]      out_pc1,
    output logic [14:0]      out_pc2,
    output logic [31:0]      out_instr1,
    output logic [31:0]      out_instr2,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 47;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] free_slots;
    logic [1:0]       n_enq;
    logic [1:0]       n_deq;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [ENT_W-1:0] ent1;
    logic [ENT_W-1:0] ent2;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

    // Acceptance uses only the start-of-cycle count. There is no bypass from dequeue.
    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign in_ready   = !reset && !flush && (free_slots >= CNT_W'(2));

    // A lone slot 2 without slot 1 is dropped.
    assign n_enq = in_ready ? ({1'b0, in_valid1} + {1'b0, in_valid1 & in_valid2}) : 2'd0;

    assign out_valid1 = (count_q != '0);
    assign out_valid2 = (count_q >= CNT_W'(2));

    // A dequeue on an empty slot is ignored.
    assign n_deq = {1'b0, deq1 & out_valid1} + {1'b0, deq1 & deq2 & out_valid2};

    assign ent1       = mem_q[rd_ptr_q];
    assign ent2       = mem_q[rd_ptr_p1];
    assign out_pc1    = out_valid1 ? ent1[46:32] : 15'd0;
    assign out_instr1 = out_valid1 ? ent1[31:0]  : NOP;
    assign out_pc2    = out_valid2 ? ent2[46:32] : 15'd0;
    assign out_instr2 = out_valid2 ? ent2[31:0]  : NOP;
    assign count      = count_q;

    // Next-state pointers and count. Flush discards any same-cycle enqueue or dequeue.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
        count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register. Reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage. Slot 1 is written at wr_ptr and slot 2 at the next index (with wrap).
    // n_enq is already zero during reset and flush.
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) begin
            mem_q[wr_ptr_q] <= {in_pc1, in_instr1};
        end
        if (n_enq == 2'd2) begin
            mem_q[wr_ptr_p1] <= {in_pc2, in_instr2};
        end
    end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Testbench for fetch_pair_queue. The reference model is a plain queue of
// {pc, instr} entries, and it is updated once per clock from the documented rules.
module tb_fetch_pair_queue;

  localparam int          DEPTH = 8;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid1 = 1'b0;
  logic             in_valid2 = 1'b0;
  logic [14:0]      in_pc1 = '0;
  logic [14:0]      in_pc2 = '0;
  logic [31:0]      in_instr1 = '0;
  logic [31:0]      in_instr2 = '0;
  logic             in_ready;
  logic             deq1 = 1'b0;
  logic             deq2 = 1'b0;
  logic             out_valid1;
  logic             out_valid2;
  logic [14:0]      out_pc1;
  logic [14:0]      out_pc2;
  logic [31:0]      out_instr1;
  logic [31:0]      out_instr2;
  logic [CNT_W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  bit state_known = 1'b0;

  logic [46:0] model_q[$];

  fetch_pair_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_pc1(in_pc1), .in_pc2(in_pc2),
    .in_instr1(in_instr1), .in_instr2(in_instr2),
    .in_ready(in_ready), .deq1(deq1), .deq2(deq2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_pc2(out_pc2),
    .out_instr1(out_instr1), .out_instr2(out_instr2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check all outputs against the model, then advance the model.
  task automatic step(input logic rst, input logic fl,
                      input logic v1, input logic v2,
                      input logic [14:0] p1, input logic [14:0] p2,
                      input logic [31:0] i1, input logic [31:0] i2,
                      input logic d1, input logic d2);
    int  sz;
    bit  exp_ready;
    @(negedge clk);
    reset = rst; flush = fl;
    in_valid1 = v1; in_valid2 = v2;
    in_pc1 = p1; in_pc2 = p2; in_instr1 = i1; in_instr2 = i2;
    deq1 = d1; deq2 = d2;
    #1;
    sz = model_q.size();
    exp_ready = !rst && !fl && ((DEPTH - sz) >= 2);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    if (state_known) begin
      chk("count", 64'(count), 64'(sz));
      chk("out_valid1", 64'(out_valid1), 64'(sz >= 1));
      chk("out_valid2", 64'(out_valid2), 64'(sz >= 2));
      chk("out_pc1", 64'(out_pc1), (sz >= 1) ? 64'(model_q[0][46:32]) : 64'd0);
      chk("out_instr1", 64'(out_instr1), (sz >= 1) ? 64'(model_q[0][31:0]) : 64'(NOP));
      chk("out_pc2", 64'(out_pc2), (sz >= 2) ? 64'(model_q[1][46:32]) : 64'd0);
      chk("out_instr2", 64'(out_instr2), (sz >= 2) ? 64'(model_q[1][31:0]) : 64'(NOP));
    end
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
      if (rst) state_known = 1'b1;
    end else begin
      if (d1 && sz >= 1) void'(model_q.pop_front());
      if (d1 && d2 && sz >= 2) void'(model_q.pop_front());
      if (exp_ready && v1) model_q.push_back({p1, i1});
      if (exp_ready && v1 && v2) model_q.push_back({p2, i2});
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic push_pair(input logic [14:0] p, input logic [31:0] i);
    step(0, 0, 1, 1, p, p + 15'd4, i, i + 32'd1, 0, 0);
  endtask

  task automatic peek_after();
    @(negedge clk);
    reset = 0; flush = 0; in_valid1 = 0; in_valid2 = 0; deq1 = 0; deq2 = 0;
    #1;
  endtask

  initial begin
    // Reset for two cycles. in_ready stays low while reset is high.
    step(1, 0, 0, 0, '0, '0, '0, '0, 0, 0);
    step(1, 0, 1, 1, 15'h10, 15'h14, 32'h1, 32'h2, 1, 1);
    idle();
    chk("post_reset_count", 64'(count), 64'd0);
    chk("post_reset_instr1", 64'(out_instr1), 64'(NOP));

    // A pair into an empty queue is visible on the next cycle.
    step(0, 0, 1, 1, 15'h000, 15'h004, 32'hAAAA0001, 32'hBBBB0002, 0, 0);
    peek_after();
    chk("first_pair_pc1", 64'(out_pc1), 64'h000);
    chk("first_pair_pc2", 64'(out_pc2), 64'h004);
    chk("first_pair_count", 64'(count), 64'd2);
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 1);

    // Fill to DEPTH, then present a fifth pair that must be refused.
    for (int k = 0; k < 4; k++) push_pair(15'(16 * k + 15'h020), 32'h1000 + 32'(k));
    peek_after();
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(in_ready), 64'd0);
    push_pair(15'h300, 32'hDEAD);
    peek_after();
    chk("fifth_refused", 64'(count), 64'd8);
    step(0, 0, 1, 1, 15'h300, 15'h304, 32'hDEAD, 32'hDEAE, 1, 0);
    peek_after();
    chk("deq1_count", 64'(count), 64'd7);
    chk("deq1_ready", 64'(in_ready), 64'd0);
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 1);
    peek_after();
    chk("deq2_count", 64'(count), 64'd5);
    chk("deq2_ready", 64'(in_ready), 64'd1);

    // From count 3, a simultaneous pair enqueue and double dequeue leaves count at 3.
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 1);
    push_pair(15'h400, 32'h4000);
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 1);
    step(0, 0, 1, 1, 15'h410, 15'h414, 32'h4100, 32'h4101, 1, 1);
    peek_after();
    chk("simul_count", 64'(count), 64'd3);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0, '0, '0, '0, 1, 0);

    // Wrap: flush to index 0, then write 7 entries and drain them. Both pointers end at 7.
    step(0, 1, 0, 0, '0, '0, '0, '0, 0, 0);
    for (int k = 0; k < 3; k++) push_pair(15'(8 * k + 15'h040), 32'h5000 + 32'(k));
    step(0, 0, 1, 0, 15'h070, '0, 32'h5100, '0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0, '0, '0, '0, 1, 1);
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 0);
    step(0, 0, 1, 1, 15'h100, 15'h104, 32'h6000, 32'h6001, 0, 0);
    peek_after();
    chk("wrap_pc1", 64'(out_pc1), 64'h100);
    chk("wrap_pc2", 64'(out_pc2), 64'h104);
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 0);
    peek_after();
    chk("wrap_next_pc1", 64'(out_pc1), 64'h104);
    step(0, 0, 0, 0, '0, '0, '0, '0, 1, 0);

    // Flush at count 5, with a pair and a dequeue in the same cycle. Both are discarded.
    push_pair(15'h200, 32'h7000);
    push_pair(15'h210, 32'h7010);
    step(0, 0, 1, 0, 15'h220, '0, 32'h7020, '0, 0, 0);
    peek_after();
    chk("pre_flush_count", 64'(count), 64'd5);
    step(0, 1, 1, 1, 15'h230, 15'h234, 32'h7030, 32'h7031, 1, 0);
    peek_after();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid1", 64'(out_valid1), 64'd0);
    push_pair(15'h500, 32'h8000);
    peek_after();
    chk("post_flush_count", 64'(count), 64'd2);
    chk("post_flush_pc1", 64'(out_pc1), 64'h500);

    // Randomized traffic, with occasional flushes and resets.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           15'($urandom_range(0, 32767)), 15'($urandom_range(0, 32767)),
           $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
